sram_packet_serializer: RTL
===========================

// Module: sram_packet_serializer
// PURPOSE
// - Host-side initiator for the SRAM test chip's serial GPIO path.
// - Accepts a parallel command packet, shifts it MSB-first onto the chip's serial input with a load strobe,
//   then pulses the SRAM-load strobe.
// - Optionally collects the serial read-back word (LSB-first) and returns it on a valid/ready response port.
// - Lives in the test harness / management-side logic driving gpio_bit, gpio_in_load, gpio_sram_load, gpio_data.
// PARAMETERS
// - PACKET_WIDTH   112  command packet width in bits (matches the chip's shift register)
// - DATA_WIDTH     64   read-back word width in bits
// - SETTLE_CYCLES  2    idle cycles between the sram_load pulse and the first capture (>=1)
// PORTS
// - clk        in   1             clock; all logic on rising edge
// - reset      in   1             reset: synchronous, active-high
// - cmd_valid  in   1             command packet valid
// - cmd_ready  out  1             high only in IDLE; transfer on cmd_valid&&cmd_ready
// - cmd_packet in   PACKET_WIDTH  packet to serialize
// - cmd_read   in   1             1 = perform read-back capture after the load
// - ser_bit    out  1             serial data to chip (gpio_bit)
// - ser_load   out  1             shift enable to chip (gpio_in_load)
// - sram_load  out  1             one-cycle SRAM operation strobe (gpio_sram_load)
// - ser_in     in   1             serial read data from chip (gpio_data)
// - cap_en     out  1             high during capture cycles (chip's read shift enable)
// - rsp_valid  out  1             response valid; held until rsp_ready
// - rsp_ready  in   1             response accept
// - rsp_data   out  DATA_WIDTH    collected read word
// - busy       out  1             high in any state except IDLE
// BEHAVIOUR
// - Reset (any state, incl. mid-shift): next cycle in IDLE; outputs ser_bit=0, ser_load=0, sram_load=0,
//   cap_en=0, rsp_valid=0, rsp_data=0, busy=0, cmd_ready=1. Shift/capture registers and counter cleared.
// - FSM: IDLE -> SHIFT -> LOAD -> (cmd_read ? WAIT -> CAPTURE : -) -> DONE -> IDLE.
// - IDLE: cmd_ready=1. Handshake at edge T latches cmd_packet and cmd_read; go to SHIFT.
// - SHIFT: cycles T+1..T+PACKET_WIDTH: ser_load=1, ser_bit=packet[PACKET_WIDTH-1-i] for cycle i (MSB first).
//   After the last bit, the chip's register equals cmd_packet.
// - LOAD: exactly one cycle; sram_load=1, ser_load=0.
//   If cmd_read=1, go to WAIT; otherwise set rsp_data=0 and go to DONE.
// - WAIT: SETTLE_CYCLES cycles with all strobes low.
// - CAPTURE: DATA_WIDTH cycles with cap_en=1. Each edge: shreg <= {ser_in, shreg[DATA_WIDTH-1:1]},
//   so the first bit received lands at bit 0. On exit, rsp_data <= shreg.
// - DONE: rsp_valid=1, rsp_data stable. On rsp_valid&&rsp_ready, go to IDLE; cmd_ready rises the next cycle
//   (no same-cycle rsp/cmd overlap).
// - cmd_valid outside IDLE is ignored; cmd_packet is sampled only at the handshake, so later changes
//   have no effect.
// - Counter: single down-counter of width $clog2(max(PACKET_WIDTH,DATA_WIDTH,SETTLE_CYCLES)+2),
//   reloaded on each state entry, with no wrap. State exits on count==0.
// - Latency (cmd_read=1): handshake to rsp_valid = PACKET_WIDTH + 1 + SETTLE_CYCLES + DATA_WIDTH + 1 cycles.
// CONFIGURATION
// - SER_PARITY_EN defined:
//   - SHIFT lasts PACKET_WIDTH+1 cycles; the extra final bit is the even parity ^cmd_packet.
//   - CAPTURE lasts DATA_WIDTH+1 cycles; the final ser_in bit is a parity bit that is not stored.
//   - Extra output rsp_perr (1 bit) is valid with rsp_valid; it equals (^rsp_data) ^ parity_bit,
//     is 0 when cmd_read=0, and resets to 0.
// - SER_PARITY_EN undefined: no parity bits, no rsp_perr port; timing as in BEHAVIOUR.
// TESTING
// - Reset held 3 cycles mid-SHIFT (bit 40) -> next cycle all outputs 0, cmd_ready=1; a new command then
//   shifts from its MSB.
// - cmd_packet=112'h8000_..._0001, cmd_read=0 -> ser_bit=1 in the first and last SHIFT cycles, 0 elsewhere;
//   ser_load high exactly 112 cycles; sram_load high 1 cycle;
//   rsp_valid at handshake+114 with rsp_data=0.
// - cmd_read=1, chip model returns 64'hDEAD_BEEF_0123_4567 LSB-first -> rsp_data=64'hDEAD_BEEF_0123_4567;
//   cap_en high exactly 64 cycles starting 2 cycles after sram_load.
// - rsp_ready held low 10 cycles in DONE -> rsp_valid and rsp_data stable; cmd_valid=1 throughout is not
//   accepted until the cycle after the rsp handshake.
// - Back-to-back commands with cmd_valid always high -> exactly one idle IDLE cycle between DONE and the
//   next SHIFT; no dropped or duplicated bits.
// - (SER_PARITY_EN) packet with three 1s -> 113th ser_bit=1; injected flipped read bit -> rsp_perr=1.

Source files
------------

// File: rtl/sram_packet_serializer.sv
// sram_packet_serializer
// Host-side initiator for the SRAM test chip's serial GPIO path. A parallel
// command packet is shifted MSB-first onto the chip's serial input, followed
// by a one-cycle SRAM-load strobe. An optional read-back word is then
// collected LSB-first and returned on a valid/ready response port.
// Optional feature macro: SER_PARITY_EN (appends an even-parity bit to the
// shifted packet and checks a trailing parity bit on the read-back word).
module sram_packet_serializer #(
  parameter int PACKET_WIDTH  = 112,
  parameter int DATA_WIDTH    = 64,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [PACKET_WIDTH-1:0] cmd_packet,
  input  logic                    cmd_read,
  output logic                    ser_bit,
  output logic                    ser_load,
  output logic                    sram_load,
  input  logic                    ser_in,
  output logic                    cap_en,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    busy
`ifdef SER_PARITY_EN
  ,
  output logic                    rsp_perr
`endif
);

`ifdef SER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  // Number of serial bits sent and received, including any parity bit
  localparam int SHIFT_LEN = PACKET_WIDTH + PAR;
  localparam int CAP_LEN   = DATA_WIDTH + PAR;

  // One down-counter covers every timed state; sized for the longest one
  localparam int MAX_A   = (PACKET_WIDTH > DATA_WIDTH) ? PACKET_WIDTH : DATA_WIDTH;
  localparam int MAX_LEN = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
  localparam int CW      = $clog2(MAX_LEN + 2);

  localparam logic [CW-1:0] C_SHIFT  = CW'(SHIFT_LEN - 1);
  localparam logic [CW-1:0] C_SETTLE = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] C_CAP    = CW'(CAP_LEN - 1);
  localparam logic [CW-1:0] C_ONE    = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_LOAD,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic [SHIFT_LEN-1:0]    r_pkt;
  logic [DATA_WIDTH-1:0]   r_shreg;
  logic                    r_read;
  logic                    r_cmd_ready;
  logic                    r_busy;
  logic                    r_ser_bit;
  logic                    r_ser_load;
  logic                    r_sram_load;
  logic                    r_cap_en;
  logic                    r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_data;
`ifdef SER_PARITY_EN
  logic                    r_perr;
`endif

  logic [SHIFT_LEN-1:0]    w_pkt_init;
  logic [DATA_WIDTH-1:0]   w_shreg_next;

`ifdef SER_PARITY_EN
  // Even parity of the packet travels as the final serial bit
  assign w_pkt_init = {cmd_packet, ^cmd_packet};
`else
  assign w_pkt_init = cmd_packet;
`endif

  // Read-back arrives LSB first, so new bits enter at the top and move down
  assign w_shreg_next = {ser_in, r_shreg[DATA_WIDTH-1:1]};

  // Sequencer: shift packet, strobe load, settle, capture, hold response
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_pkt       <= '0;
      r_shreg     <= '0;
      r_read      <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_ser_bit   <= 1'b0;
      r_ser_load  <= 1'b0;
      r_sram_load <= 1'b0;
      r_cap_en    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
`ifdef SER_PARITY_EN
      r_perr      <= 1'b0;
`endif
    end else begin
      r_sram_load <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_state     <= S_SHIFT;
            r_pkt       <= w_pkt_init;
            r_read      <= cmd_read;
            r_ser_bit   <= w_pkt_init[SHIFT_LEN-1];
            r_ser_load  <= 1'b1;
            r_cnt       <= C_SHIFT;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (r_cnt == '0) begin
            r_state     <= S_LOAD;
            r_ser_load  <= 1'b0;
            r_ser_bit   <= 1'b0;
            r_sram_load <= 1'b1;
          end else begin
            r_pkt     <= {r_pkt[SHIFT_LEN-2:0], 1'b0};
            r_ser_bit <= r_pkt[SHIFT_LEN-2];
            r_cnt     <= r_cnt - C_ONE;
          end
        end
        S_LOAD: begin
          if (r_read) begin
            r_state <= S_WAIT;
            r_cnt   <= C_SETTLE;
          end else begin
            r_state     <= S_DONE;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= '0;
`ifdef SER_PARITY_EN
            r_perr      <= 1'b0;
`endif
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_state  <= S_CAPTURE;
            r_cap_en <= 1'b1;
            r_cnt    <= C_CAP;
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
        S_CAPTURE: begin
          if (r_cnt == '0) begin
            r_state     <= S_DONE;
            r_cap_en    <= 1'b0;
            r_rsp_valid <= 1'b1;
`ifdef SER_PARITY_EN
            // Final bit is the chip's parity bit: checked, never stored
            r_rsp_data  <= r_shreg;
            r_perr      <= (^r_shreg) ^ ser_in;
`else
            r_shreg     <= w_shreg_next;
            r_rsp_data  <= w_shreg_next;
`endif
          end else begin
            r_shreg <= w_shreg_next;
            r_cnt   <= r_cnt - C_ONE;
          end
        end
        S_DONE: begin
          // cmd_ready returns only after the response is consumed
          if (rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign ser_bit   = r_ser_bit;
  assign ser_load  = r_ser_load;
  assign sram_load = r_sram_load;
  assign cap_en    = r_cap_en;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
`ifdef SER_PARITY_EN
  assign rsp_perr  = r_perr;
`endif

endmodule
